score_display: RTL and testbench



---
 rtl/score_display_pkg.sv | 17 +
 rtl/score_display_glyph_rom.sv | 51 +++++
 rtl/score_display.sv | 189 ++++++++++++++++++
 tb/tb_score_display.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and glyph geometry for the score_display overlay.
// Consumers: score_display (top) and score_display_glyph_rom.
package score_display_pkg;

    typedef logic [3:0] bcd_t;

    localparam int GLYPH_W = 12;
    localparam int GLYPH_H = 13;
    localparam int COLOR_W = 12;

    localparam logic [COLOR_W-1:0] FG_COLOR = 12'hFF0;

    function automatic int digits_w(input int n);
        return 4 * n;
    endfunction

endpackage

// File: rtl/score_display_glyph_rom.sv
// Seven-segment style 12x13 digit glyphs, one cycle read latency.
// Pixels outside the glyph cell or for non-decimal nibbles read as 0.
module glyph_rom
    import score_display_pkg::*;
(
    input  logic               clk,
    input  bcd_t               digit,
    input  logic [3:0]         row,
    input  logic [3:0]         col,
    output logic [COLOR_W-1:0] color
);

    logic [6:0] segs;
    logic [6:0] hit;
    logic       in_cell;
    logic       lit;

    always_comb begin
        segs = 7'b0000000;
        unique case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
    end

    // Segment order {a,b,c,d,e,f,g}; verticals overlap the bars.
    assign hit[6] = (row <= 4'd1);
    assign hit[5] = (col >= 4'd10) && (row <= 4'd6);
    assign hit[4] = (col >= 4'd10) && (row >= 4'd6);
    assign hit[3] = (row >= 4'd11);
    assign hit[2] = (col <= 4'd1) && (row >= 4'd6);
    assign hit[1] = (col <= 4'd1) && (row <= 4'd6);
    assign hit[0] = (row == 4'd6);

    assign in_cell = (col < 4'(GLYPH_W)) && (row < 4'(GLYPH_H));
    assign lit     = in_cell && |(segs & hit);

    always_ff @(posedge clk) begin
        color <= lit ? FG_COLOR : '0;
    end

endmodule

// File: rtl/score_display.sv
// N-digit saturating BCD counter with a 2-cycle pipelined pixel overlay.
// Define SCORE_BLINK_EN to blink the digits for BLINK_FRAMES after a change.
module score_display
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int X0           = 300,
    parameter int Y0           = 60,
    parameter int GLYPH_W      = score_display_pkg::GLYPH_W,
    parameter int GLYPH_H      = score_display_pkg::GLYPH_H,
    parameter int GAP          = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    clr,
    input  logic                    frame_tick,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    ovf,
    output logic [COLOR_W-1:0]      rgb,
    output logic                    disp_on
);

    localparam int VW    = digits_w(NUM_DIGITS);
    localparam int PITCH = GLYPH_W + GAP;
    localparam int BOX_W = NUM_DIGITS * GLYPH_W + (NUM_DIGITS - 1) * GAP;

    localparam logic [VW-1:0] ALL9 = {NUM_DIGITS{4'h9}};

    function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [VW-1:0] value_q, value_d;
    logic [VW-1:0] shown_q;
    logic          ovf_q, ovf_d;

    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc && dec) begin
            value_d = value_q;
        end else if (inc) begin
            if (value_q == ALL9) ovf_d = 1'b1;
            else                 value_d = bcd_inc(value_q);
        end else if (dec) begin
            if (value_q != '0) value_d = bcd_dec(value_q);
        end
    end

    logic blank_c;

`ifdef SCORE_BLINK_EN
    localparam int BW = (BLINK_FRAMES < 8) ? 3 : $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (clr || (value_d != value_q)) begin
            blink_d = BW'(BLINK_FRAMES);
        end else if (frame_tick && (blink_q != '0)) begin
            blink_d = blink_q - BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_q <= '0;
        else        blink_q <= blink_d;
    end

    assign blank_c = (blink_q != '0) && blink_q[2];
`else
    assign blank_c = (BLINK_FRAMES < 0);
`endif

    // Walk the digit pitch with a subtract chain instead of dividing.
    logic [9:0] rem_c;
    logic [1:0] idx_c;
    logic       in_box_c;
    logic       gap_c;
    bcd_t       nib_c;
    logic [3:0] row_c;

    always_comb begin
        rem_c = x - 10'(X0);
        idx_c = 2'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (rem_c >= 10'(PITCH)) begin
                rem_c = rem_c - 10'(PITCH);
                idx_c = idx_c + 2'd1;
            end
        end
        nib_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_c == 2'(i)) nib_c = shown_q[4*(NUM_DIGITS-1-i) +: 4];
        end
    end

    assign in_box_c = (x >= 10'(X0)) && (x < 10'(X0 + BOX_W)) &&
                      (y >= 10'(Y0)) && (y < 10'(Y0 + GLYPH_H));
    assign gap_c    = (rem_c >= 10'(GLYPH_W));
    assign row_c    = 4'(y - 10'(Y0));

    logic       in_box_q, gap_q, blank_q, disp_on_q;
    logic [3:0] col_q, row_q;
    bcd_t       nib_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            ovf_q     <= 1'b0;
            shown_q   <= '0;
            in_box_q  <= 1'b0;
            gap_q     <= 1'b0;
            blank_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            nib_q     <= '0;
            disp_on_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            ovf_q     <= ovf_d;
            if (frame_tick) shown_q <= value_q;
            in_box_q  <= in_box_c;
            gap_q     <= gap_c;
            blank_q   <= blank_c;
            col_q     <= rem_c[3:0];
            row_q     <= row_c;
            nib_q     <= nib_c;
            disp_on_q <= in_box_q & ~gap_q & ~blank_q;
        end
    end

    logic [COLOR_W-1:0] rom_color;

    glyph_rom u_rom (
        .clk   (clk),
        .digit (nib_q),
        .row   (row_q),
        .col   (col_q),
        .color (rom_color)
    );

    assign value   = value_q;
    assign ovf     = ovf_q;
    assign disp_on = disp_on_q;
    assign rgb     = disp_on_q ? rom_color : '0;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: counter checks inline, pixel
// expectations queued at drive time and retired by a monitor 2 cycles on.
module tb_score_display;

    localparam logic [11:0] FG = 12'hFF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        clr = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [11:0] value;
    logic        ovf;
    logic [11:0] rgb;
    logic        disp_on;

    always #5 clk = ~clk;

    score_display dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (inc),
        .dec        (dec),
        .clr        (clr),
        .frame_tick (frame_tick),
        .x          (x),
        .y          (y),
        .value      (value),
        .ovf        (ovf),
        .rgb        (rgb),
        .disp_on    (disp_on)
    );

    typedef struct {
        logic        on;
        logic [11:0] rgb;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   m_val = 0;
    bit   m_ovf = 1'b0;
    int   m_blink = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit blanked();
`ifdef SCORE_BLINK_EN
        return (m_blink != 0) && (m_blink[2] == 1'b1);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (disp_on !== e.on || rgb !== e.rgb)
                    $display("FAIL %s: disp_on=%b rgb=%h, expected disp_on=%b rgb=%h",
                             e.name, disp_on, rgb, e.on, e.rgb);
                else
                    n_pass++;
            end
        end
    end

    task automatic pulse(input bit i, input bit d, input bit c, input bit f);
        int old;
        @(negedge clk);
        inc = i; dec = d; clr = c; frame_tick = f;
        old = m_val;
        if (c) begin
            m_val = 0;
            m_ovf = 1'b0;
        end else if (i && d) begin
            m_val = old;
        end else if (i) begin
            if (m_val == 999) m_ovf = 1'b1;
            else              m_val++;
        end else if (d) begin
            if (m_val > 0) m_val--;
        end
        if (c || m_val != old)        m_blink = 32;
        else if (f && m_blink > 0)    m_blink--;
        @(negedge clk);
        inc = 1'b0; dec = 1'b0; clr = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic probe(input int px, input int py, input bit on,
                         input logic [11:0] c, input string nm);
        exp_t e;
        bit   vis;
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        vis = on && !blanked();
        e.on = vis;
        e.rgb = vis ? c : 12'h000;
        e.due = cyc + 2;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d pixels pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (value !== 12'h000) $display("FAIL rst_value: got %h want 000", value);
        else n_pass++;
        n_checks++;
        if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf);
        else n_pass++;
        n_checks++;
        if (disp_on !== 1'b0 || rgb !== 12'h000)
            $display("FAIL rst_disp: got %b/%h want 0/000", disp_on, rgb);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_count3();
        repeat (3) pulse(1, 0, 0, 0);
        n_checks++;
        if (value !== 12'h003) $display("FAIL count3: got %h want 003", value);
        else n_pass++;
        probe(328, 63, 1, FG, "shown_pre_tick");
        drain();
        pulse(0, 0, 0, 1);
        probe(328, 63, 1, 12'h000, "shown_post_tick");
        drain();
    endtask

    task automatic test_saturate();
        while (m_val < 999) pulse(1, 0, 0, 0);
        n_checks++;
        if (value !== 12'h999 || ovf !== 1'b0)
            $display("FAIL at999: got %h/%b want 999/0", value, ovf);
        else n_pass++;
        pulse(1, 0, 0, 0);
        n_checks++;
        if (value !== 12'h999 || ovf !== 1'b1)
            $display("FAIL sat_inc: got %h/%b want 999/1", value, ovf);
        else n_pass++;
        pulse(0, 0, 1, 0);
        n_checks++;
        if (value !== 12'h000 || ovf !== 1'b0)
            $display("FAIL clr: got %h/%b want 000/0", value, ovf);
        else n_pass++;
    endtask

    task automatic test_dec_floor();
        pulse(0, 1, 0, 0);
        n_checks++;
        if (value !== 12'h000 || ovf !== m_ovf)
            $display("FAIL dec0: got %h/%b want 000/%b", value, ovf, m_ovf);
        else n_pass++;
        repeat (5) pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        n_checks++;
        if (value !== 12'h005) $display("FAIL incdec: got %h want 005", value);
        else n_pass++;
        pulse(0, 1, 0, 0);
        n_checks++;
        if (value !== to_bcd(m_val)) $display("FAIL dec: got %h want 004", value);
        else n_pass++;
    endtask

    task automatic test_tick_collision();
        pulse(0, 0, 1, 0);
        repeat (41) pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 1);
        n_checks++;
        if (value !== 12'h042) $display("FAIL coll_value: got %h want 042", value);
        else n_pass++;
        probe(328, 60, 1, 12'h000, "coll_shown041");
        drain();
        pulse(0, 0, 0, 1);
        probe(328, 60, 1, FG, "coll_shown042");
        drain();
    endtask

    task automatic test_back_to_back_pixels();
        pulse(0, 0, 1, 0);
        repeat (123) pulse(1, 0, 0, 0);
        repeat (33) pulse(0, 0, 0, 1);
        probe(300, 60, 1, 12'h000, "px_d1_c0r0");
        probe(311, 63, 1, FG,      "px_d1_c11r3");
        probe(312, 60, 0, 12'h000, "px_gap312");
        probe(313, 60, 0, 12'h000, "px_gap313");
        probe(314, 60, 1, FG,      "px_d2_c0r0");
        probe(314, 63, 1, 12'h000, "px_d2_c0r3");
        probe(328, 60, 1, FG,      "px_d3_c0r0");
        probe(339, 60, 1, FG,      "px_d3_c11r0");
        probe(340, 60, 0, 12'h000, "px_x340");
        probe(341, 60, 0, 12'h000, "px_x341");
        probe(300, 72, 1, 12'h000, "px_row12");
        probe(300, 73, 0, 12'h000, "px_y73");
        probe(299, 60, 0, 12'h000, "px_x299");
        probe(300, 59, 0, 12'h000, "px_y59");
        drain();
    endtask

    task automatic test_midreset();
        probe(300, 60, 1, 12'h000, "pre_rst");
        drain();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (disp_on !== 1'b0 || rgb !== 12'h000 || value !== 12'h000)
            $display("FAIL midrst: got %b/%h/%h want 0/000/000", disp_on, rgb, value);
        else n_pass++;
        m_val = 0;
        m_ovf = 1'b0;
        m_blink = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (disp_on !== 1'b0) $display("FAIL rst_release: got %b want 0", disp_on);
        else n_pass++;
        probe(300, 60, 1, FG, "post_rst");
        drain();
    endtask

    task automatic test_blink();
        pulse(1, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            pulse(0, 0, 0, 1);
            probe(311, 63, 1, FG, $sformatf("blink_f%0d", k));
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_count3();
        test_saturate();
        test_dec_floor();
        test_tick_collision();
        test_back_to_back_pixels();
        test_midreset();
        test_blink();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
